// File: rtl/usb_rx_deframer_pkg.sv
// Shared USB line constants and the unstuffer result bundle.
// The stuffing length is reused by the TX stuffer.
package usb_rx_deframer_pkg;
    localparam int         USB_STUFF_LEN    = 6;
    localparam logic [7:0] USB_SYNC_PATTERN = 8'h80;

    typedef struct packed {
        logic data_stb;   // strobe carrying a real (non-stuffed) data bit
        logic stuff_err;  // one too many consecutive 1s
    } unstuff_t;
endpackage

// File: rtl/usb_rx_unstuff.sv
// Counts consecutive 1s inside a packet, drops stuffed 0s and flags stuff violations.
// The result is combinational so the parent can register its pulses on the same strobe.
module usb_rx_unstuff
    import usb_rx_deframer_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     bit_strobe,
    input  logic     bit_in,
    input  logic     se0,
    input  logic     in_data,
    input  logic     sync_end,
    output unstuff_t us
);
    localparam int CW = $clog2(STUFF_LEN + 1);

    logic [CW-1:0] ones;
    logic          strobing;
    logic          at_limit;

    assign strobing     = bit_strobe & in_data & ~se0;
    assign at_limit     = (ones == CW'(STUFF_LEN));
    assign us.data_stb  = strobing & ~at_limit;
    assign us.stuff_err = strobing & at_limit & bit_in;

    // SYNC's final 1 already counts toward the stuffing run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ones <= '0;
        else if (sync_end)
            ones <= CW'(1);
        else if (strobing)
            ones <= (at_limit || !bit_in) ? '0 : ones + 1'b1;
    end
endmodule

// File: rtl/usb_rx_deframer.sv
// USB RX deframer: SYNC hunt, byte assembly (LSB first) and EOP/error framing.
// Bit unstuffing is delegated to usb_rx_unstuff.
module usb_rx_deframer
    import usb_rx_deframer_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = 3,
    parameter int STUFF_LEN      = USB_STUFF_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       bit_strobe,
    input  logic       bit_in,
    input  logic       se0,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       pkt_end,
    output logic       err_stuff,
    output logic       err_align
);
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_EOP} state_t;

    state_t     state;
    logic [2:0] zcnt;
    logic [2:0] bcnt;
    logic [7:0] sh;
    logic       se0_seen;
    logic       sync_end;
    logic [7:0] sh_next;
    unstuff_t   us;

    assign sync_end = bit_strobe && (state == S_IDLE) && !se0 && bit_in
                      && (zcnt >= 3'(SYNC_MIN_ZEROS));
    assign sh_next  = {bit_in, sh[7:1]};

    usb_rx_unstuff #(.STUFF_LEN(STUFF_LEN)) u_unstuff (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_strobe (bit_strobe),
        .bit_in     (bit_in),
        .se0        (se0),
        .in_data    (state == S_DATA),
        .sync_end   (sync_end),
        .us         (us)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            zcnt      <= '0;
            bcnt      <= '0;
            sh        <= '0;
            se0_seen  <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_active <= 1'b0;
            pkt_end   <= 1'b0;
            err_stuff <= 1'b0;
            err_align <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            pkt_end   <= 1'b0;
            err_stuff <= 1'b0;
            err_align <= 1'b0;
            if (bit_strobe) begin
                case (state)
                    S_IDLE: if (!se0) begin
                        if (!bit_in) begin
                            if (zcnt != 3'd7) zcnt <= zcnt + 3'd1;
                        end else if (sync_end) begin
                            state     <= S_DATA;
                            rx_active <= 1'b1;
                            bcnt      <= '0;
                            zcnt      <= '0;
                        end else begin
                            zcnt <= '0;
                        end
                    end
                    // se0 outranks both the stuff check and byte completion.
                    S_DATA: if (se0) begin
                        pkt_end   <= (bcnt == 3'd0);
                        err_align <= (bcnt != 3'd0);
                        rx_active <= 1'b0;
                        se0_seen  <= 1'b1;
                        state     <= S_EOP;
                    end else if (us.stuff_err) begin
                        err_stuff <= 1'b1;
                        rx_active <= 1'b0;
                        se0_seen  <= 1'b0;
                        state     <= S_EOP;
                    end else if (us.data_stb) begin
                        sh   <= sh_next;
                        bcnt <= bcnt + 3'd1;
                        if (bcnt == 3'd7) begin
                            rx_data  <= sh_next;
                            rx_valid <= 1'b1;
                        end
                    end
                    // Wait for SE0, then leave on the first non-SE0 (J) strobe.
                    S_EOP: if (se0) begin
                        se0_seen <= 1'b1;
                    end else if (se0_seen) begin
                        state <= S_IDLE;
                        zcnt  <= '0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_deframer.sv
// Scoreboard bench for usb_rx_deframer: stimulus pushes expected pulses,
// a negedge monitor pops and compares whenever the DUT pulses.
module tb_usb_rx_deframer;
    localparam int EV_BYTE  = 0;
    localparam int EV_END   = 1;
    localparam int EV_STUFF = 2;
    localparam int EV_ALIGN = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       bit_in = 1'b1;
    logic       se0 = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_active, pkt_end, err_stuff, err_align;

    int  checks = 0;
    int  errors = 0;
    int  gap = 1;
    ev_t exp_q[$];

    always #5 clk = ~clk;

    usb_rx_deframer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_strobe (bit_strobe),
        .bit_in     (bit_in),
        .se0        (se0),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_active  (rx_active),
        .pkt_end    (pkt_end),
        .err_stuff  (err_stuff),
        .err_align  (err_align)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (gap %0d)", nm, act, exp, gap);
        end
    endtask

    task automatic expect_ev(input int k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input int k, input string nm);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected pulse (data %h), nothing expected (gap %0d)", nm, rx_data, gap);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || (k == EV_BYTE && e.data !== rx_data)) begin
                errors++;
                $display("FAIL %s: got kind %0d data %h, expected kind %0d data %h (gap %0d)",
                         nm, k, rx_data, e.kind, e.data, gap);
            end
        end
        // Framing pulses coincide with rx_active dropping.
        if (k != EV_BYTE) chk({nm, "_active_low"}, {7'd0, rx_active}, 8'd0);
    endtask

    always @(negedge clk) begin
        if (rx_valid)  pop_cmp(EV_BYTE,  "rx_valid");
        if (pkt_end)   pop_cmp(EV_END,   "pkt_end");
        if (err_stuff) pop_cmp(EV_STUFF, "err_stuff");
        if (err_align) pop_cmp(EV_ALIGN, "err_align");
    end

    task automatic strobe_bit(input logic b, input logic s);
        bit_in     = b;
        se0        = s;
        bit_strobe = 1'b1;
        @(posedge clk); #1;
        bit_strobe = 1'b0;
        for (int i = 1; i < gap; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Bits sent in time order: v[n-1] first.
    task automatic send_seq(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) strobe_bit(v[i], 1'b0);
    endtask

    task automatic eop();
        strobe_bit(1'b0, 1'b1);
        chk("active_after_se0", {7'd0, rx_active}, 8'd0);
        strobe_bit(1'b0, 1'b1);
        strobe_bit(1'b1, 1'b0);
    endtask

    task automatic sync();
        send_seq(32'b0000000, 7);
        chk("active_before_sync_end", {7'd0, rx_active}, 8'd0);
        strobe_bit(1'b1, 1'b0);
        chk("active_after_sync", {7'd0, rx_active}, 8'd1);
    endtask

    initial begin
        #12;
        chk("reset_data",   rx_data, 8'h00);
        chk("reset_active", {7'd0, rx_active}, 8'd0);
        chk("reset_pulses", {4'd0, rx_valid, pkt_end, err_stuff, err_align}, 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int g = 0; g < 2; g++) begin
            gap = (g == 0) ? 1 : 4;

            // 1: two bytes A5, C3 then good EOP (both patterns are bit-palindromes)
            send_seq(32'b111, 3);
            sync();
            expect_ev(EV_BYTE, 8'hA5);
            expect_ev(EV_BYTE, 8'hC3);
            expect_ev(EV_END, 8'h00);
            send_seq(32'b10100101, 8);
            send_seq(32'b11000011, 8);
            chk("c1_active_mid", {7'd0, rx_active}, 8'd1);
            eop();

            // 2: byte 00, then FF with stuffed 0 after six 1s, then A5 stays aligned
            sync();
            expect_ev(EV_BYTE, 8'h00);
            expect_ev(EV_BYTE, 8'hFF);
            expect_ev(EV_BYTE, 8'hA5);
            expect_ev(EV_END, 8'h00);
            send_seq(32'b00000000, 8);
            send_seq(32'b111111011, 9);
            send_seq(32'b10100101, 8);
            eop();

            // 3: SYNC's 1 + 11111 -> stuffed 0; data bits 1,1,1,1,1,0,1,0 = 5F
            sync();
            expect_ev(EV_BYTE, 8'h5F);
            expect_ev(EV_END, 8'h00);
            send_seq(32'b111110010, 9);
            eop();

            // 4: SYNC then 1s: the 6th data 1 (7th counting SYNC) is a stuff error
            sync();
            expect_ev(EV_STUFF, 8'h00);
            send_seq(32'b11111, 5);
            chk("c4_active_before_err", {7'd0, rx_active}, 8'd1);
            strobe_bit(1'b1, 1'b0);
            chk("c4_active_after_err", {7'd0, rx_active}, 8'd0);
            strobe_bit(1'b1, 1'b0);
            send_seq(32'b00000001, 8);      // SYNC-like bits ignored until SE0 then J
            send_seq(32'b10100101, 8);
            chk("c4_still_inactive", {7'd0, rx_active}, 8'd0);
            strobe_bit(1'b0, 1'b1);
            strobe_bit(1'b1, 1'b0);
            sync();
            expect_ev(EV_BYTE, 8'hA5);
            expect_ev(EV_END, 8'h00);
            send_seq(32'b10100101, 8);
            eop();

            // 5: partial byte at SE0
            sync();
            expect_ev(EV_ALIGN, 8'h00);
            send_seq(32'b10110, 5);
            eop();

            // 6: only two zeros before the 1: no SYNC
            send_seq(32'b11001, 5);
            chk("c6_short_sync", {7'd0, rx_active}, 8'd0);
            send_seq(32'b11011, 5);
            chk("c6_short_sync_later", {7'd0, rx_active}, 8'd0);

            // Reset mid-byte: outputs clear at once, no pulses
            sync();
            send_seq(32'b1010, 4);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_mid_active", {7'd0, rx_active}, 8'd0);
            chk("rst_mid_data", rx_data, 8'h00);
            @(posedge clk); @(posedge clk);
            #3 rst_n = 1'b1;
            @(posedge clk); #1;
            sync();
            expect_ev(EV_BYTE, 8'hC3);
            expect_ev(EV_END, 8'h00);
            send_seq(32'b11000011, 8);
            eop();
            chk("c6_data_hold", rx_data, 8'hC3);

            repeat (4) @(posedge clk);
            #1;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d expected pulses never seen (gap %0d)", exp_q.size(), gap);
                exp_q.delete();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end
endmodule
